// File: rtl/box_controller_if.sv
// Explosion request/response handshake between the bomb logic and box_controller.
//   exp_req/exp_x/exp_y : requester -> controller, blast cell top-left
//   exp_busy            : scan in progress, requests are dropped
//   exp_done/exp_hit    : one-cycle completion pulse and "something broke" flag
interface box_controller_if;
    logic       exp_req;
    logic [9:0] exp_x;
    logic [9:0] exp_y;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_hit;

    modport master (output exp_req, exp_x, exp_y, input  exp_busy, exp_done, exp_hit);
    modport slave  (input  exp_req, exp_x, exp_y, output exp_busy, exp_done, exp_hit);
endinterface

// File: rtl/box_controller.sv
// box_controller: owns every destructible box in the arena.
//   clk, reset (async, active low), frame_tick (one pulse per video frame)
//   v_x/v_y   : current VGA pixel -> box_on, rom_row/rom_col/rom_frame (1 cycle later)
//   b_x/b_y   : bomberman top-left -> bomberman_blocked {up,down,left,right}
//   eif       : explosion handshake (slave side), one slot scanned per cycle
//   boxes_left: number of slots not yet GONE
// box_slot holds one slot's life cycle plus its pixel/blocking hit tests.

module box_slot #(
    parameter int BOX_W       = 16,
    parameter int BOX_H       = 16,
    parameter int ANIM_FRAMES = 4,
    parameter int PX          = 0,
    parameter int PY          = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       hit_set,
    input  logic [9:0] v_x,
    input  logic [9:0] v_y,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    output logic       alive,
    output logic       gone,
    output logic       pix_hit,
    output logic [2:0] cnt,
    output logic [3:0] blk
);
    typedef enum logic [1:0] {ALIVE = 2'd0, BREAKING = 2'd1, GONE = 2'd2} slot_state_e;

    slot_state_e st_q;
    logic [2:0]  cnt_q;

    // hit_set only arrives while ALIVE, so it never collides with a tick increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q  <= ALIVE;
            cnt_q <= 3'd0;
        end else if (hit_set) begin
            st_q  <= BREAKING;
            cnt_q <= 3'd1;
        end else if (frame_tick && st_q == BREAKING) begin
            if (cnt_q == 3'(ANIM_FRAMES - 1)) begin
                st_q  <= GONE;
                cnt_q <= 3'd0;
            end else begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    // Rectangles compared in int so x+W-1 and x-1 never wrap.
    function automatic logic overlap(input int ax, input int ay);
        return (ax <= PX + BOX_W - 1) && (PX <= ax + BOX_W - 1) &&
               (ay <= PY + BOX_H - 1) && (PY <= ay + BOX_H - 1);
    endfunction

    int vx, vy, bx, by;

    always_comb begin
        vx      = int'(v_x);
        vy      = int'(v_y);
        bx      = int'(b_x);
        by      = int'(b_y);
        alive   = (st_q == ALIVE);
        gone    = (st_q == GONE);
        cnt     = cnt_q;
        pix_hit = !gone && vx >= PX && vx <= PX + BOX_W - 1 &&
                  vy >= PY && vy <= PY + BOX_H - 1;
        blk     = gone ? 4'd0 : {overlap(bx, by - 1), overlap(bx, by + 1),
                                 overlap(bx - 1, by), overlap(bx + 1, by)};
    end
endmodule

module box_controller #(
    parameter int                      NUM_BOXES   = 8,
    parameter int                      BOX_W       = 16,
    parameter int                      BOX_H       = 16,
    parameter logic [20*NUM_BOXES-1:0] BOX_POS     = '0,
    parameter int                      ANIM_FRAMES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic [9:0]             v_x,
    input  logic [9:0]             v_y,
    input  logic [9:0]             b_x,
    input  logic [9:0]             b_y,
    box_controller_if.slave        eif,
    output logic                   box_on,
    output logic [3:0]             rom_row,
    output logic [3:0]             rom_col,
    output logic [2:0]             rom_frame,
    output logic [3:0]             bomberman_blocked,
    output logic [4:0]             boxes_left
);
    localparam int IW = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} exp_state_e;

    exp_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [9:0]    ex_q, ex_d, ey_q, ey_d;
    logic          flag_q, flag_d;
    logic          busy_q, done_q, hit_q;

    logic [NUM_BOXES-1:0]       hit_set, alive, gone, pix_hit;
    logic [NUM_BOXES-1:0][2:0]  cnt;
    logic [NUM_BOXES-1:0][3:0]  blk;

    for (genvar i = 0; i < NUM_BOXES; i++) begin : g_slot
        localparam int SX = int'(BOX_POS[20*i+10 +: 10]);
        localparam int SY = int'(BOX_POS[20*i +: 10]);

        assign hit_set[i] = (state_q == S_SCAN) && (idx_q == IW'(i)) && alive[i] &&
                            (ex_q == 10'(SX)) && (ey_q == 10'(SY));

        box_slot #(
            .BOX_W(BOX_W), .BOX_H(BOX_H), .ANIM_FRAMES(ANIM_FRAMES), .PX(SX), .PY(SY)
        ) u_slot (
            .clk(clk), .reset(reset), .frame_tick(frame_tick), .hit_set(hit_set[i]),
            .v_x(v_x), .v_y(v_y), .b_x(b_x), .b_y(b_y),
            .alive(alive[i]), .gone(gone[i]), .pix_hit(pix_hit[i]),
            .cnt(cnt[i]), .blk(blk[i])
        );
    end

    // Explosion scan FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        flag_d  = flag_q;
        case (state_q)
            // done_q is high on the first IDLE cycle; a request there is dropped.
            S_IDLE: if (eif.exp_req && !done_q) begin
                ex_d    = eif.exp_x;
                ey_d    = eif.exp_y;
                flag_d  = 1'b0;
                idx_d   = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (|hit_set) flag_d = 1'b1;
                if (idx_q == IW'(NUM_BOXES - 1)) state_d = S_DONE;
                else                             idx_d   = idx_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel resolve: walk high to low so the lowest index wins.
    logic       on_d;
    logic [3:0] row_d, col_d, blk_d;
    logic [2:0] frm_d;

    always_comb begin
        on_d  = 1'b0;
        row_d = '0;
        col_d = '0;
        frm_d = '0;
        blk_d = '0;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            blk_d = blk_d | blk[i];
            if (pix_hit[i]) begin
                on_d  = 1'b1;
                row_d = 4'(v_y - BOX_POS[20*i +: 10]);
                col_d = 4'(v_x - BOX_POS[20*i+10 +: 10]);
                frm_d = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            hit_q             <= 1'b0;
            box_on            <= 1'b0;
            rom_row           <= '0;
            rom_col           <= '0;
            rom_frame         <= '0;
            bomberman_blocked <= '0;
            boxes_left        <= 5'(NUM_BOXES);
        end else begin
            busy_q            <= (state_q == S_SCAN);
            done_q            <= (state_q == S_DONE);
            hit_q             <= (state_q == S_DONE) && flag_q;
            box_on            <= on_d;
            rom_row           <= row_d;
            rom_col           <= col_d;
            rom_frame         <= frm_d;
            bomberman_blocked <= blk_d;
            boxes_left        <= 5'($countones(~gone));
        end
    end

    assign eif.exp_busy = busy_q;
    assign eif.exp_done = done_q;
    assign eif.exp_hit  = hit_q;
endmodule

// File: tb/tb_box_controller.sv
module tb_box_controller;
    localparam int N  = 8;
    localparam int W  = 16;
    localparam int H  = 16;
    localparam int AF = 4;
    localparam logic [20*N-1:0] POS = {
        10'd1016, 10'd1016, 10'd400, 10'd300, 10'd300, 10'd200, 10'd240, 10'd100,
        10'd200,  10'd100,  10'd160, 10'd48,  10'd40,  10'd40,  10'd32,  10'd32};

    int px[N] = '{32, 40, 160, 200, 240, 300, 400, 1016};
    int py[N] = '{32, 40, 48, 100, 100, 200, 300, 1016};

    logic       clk = 1'b0, reset = 1'b0, frame_tick = 1'b0;
    logic [9:0] v_x = '0, v_y = '0, b_x = '0, b_y = '0;
    logic       box_on;
    logic [3:0] rom_row, rom_col, blocked;
    logic [2:0] rom_frame;
    logic [4:0] boxes_left;

    box_controller_if bif();

    box_controller #(.NUM_BOXES(N), .BOX_W(W), .BOX_H(H), .BOX_POS(POS), .ANIM_FRAMES(AF)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .v_x(v_x), .v_y(v_y), .b_x(b_x), .b_y(b_y), .eif(bif),
        .box_on(box_on), .rom_row(rom_row), .rom_col(rom_col), .rom_frame(rom_frame),
        .bomberman_blocked(blocked), .boxes_left(boxes_left));

    always #5 clk = ~clk;

    // Reference model: slot states 0 alive / 1 breaking / 2 gone, scan phase -1 idle,
    // 0..N-1 scanning that slot, N reporting.
    int   m_st[N], m_cnt[N], m_phase;
    logic [9:0] m_ex, m_ey;
    bit   m_flag;
    bit   e_busy, e_done, e_hit, e_on;
    int   e_row, e_col, e_frame, e_blk, e_left;
    int   n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_st[i] = 0; m_cnt[i] = 0; end
        m_phase = -1; m_flag = 0;
        e_busy = 0; e_done = 0; e_hit = 0; e_on = 0;
        e_row = 0; e_col = 0; e_frame = 0; e_blk = 0; e_left = N;
    endtask

    function automatic bit ovl(input int ax, input int ay, input int i);
        return ax <= px[i] + W - 1 && px[i] <= ax + W - 1 &&
               ay <= py[i] + H - 1 && py[i] <= ay + H - 1;
    endfunction

    task automatic model_edge();
        bit done_prev;
        int vx, vy, bx, by;
        if (!reset) begin
            model_reset();
        end else begin
            vx = int'(v_x); vy = int'(v_y); bx = int'(b_x); by = int'(b_y);
            done_prev = e_done;
            e_busy = (m_phase >= 0 && m_phase < N);
            e_done = (m_phase == N);
            e_hit  = e_done && m_flag;
            e_on = 0; e_row = 0; e_col = 0; e_frame = 0; e_blk = 0; e_left = 0;
            for (int i = 0; i < N; i++) begin
                if (m_st[i] != 2) begin
                    e_left++;
                    if (!e_on && vx >= px[i] && vx < px[i] + W && vy >= py[i] && vy < py[i] + H) begin
                        e_on = 1; e_row = (vy - py[i]) % 16; e_col = (vx - px[i]) % 16;
                        e_frame = m_cnt[i];
                    end
                    if (ovl(bx, by - 1, i)) e_blk |= 8;
                    if (ovl(bx, by + 1, i)) e_blk |= 4;
                    if (ovl(bx - 1, by, i)) e_blk |= 2;
                    if (ovl(bx + 1, by, i)) e_blk |= 1;
                end
            end
            if (frame_tick)
                for (int i = 0; i < N; i++)
                    if (m_st[i] == 1) begin
                        if (m_cnt[i] + 1 == AF) begin m_st[i] = 2; m_cnt[i] = 0; end
                        else m_cnt[i]++;
                    end
            if (m_phase >= 0 && m_phase < N) begin
                if (m_st[m_phase] == 0 && px[m_phase] == int'(m_ex) && py[m_phase] == int'(m_ey)) begin
                    m_st[m_phase] = 1; m_cnt[m_phase] = 1; m_flag = 1;
                end
                m_phase++;
            end else if (m_phase == N) begin
                m_phase = -1;
            end else if (bif.exp_req && !done_prev) begin
                m_ex = bif.exp_x; m_ey = bif.exp_y; m_flag = 0; m_phase = 0;
            end
        end
    endtask

    task automatic check_all();
        check("busy", bif.exp_busy, e_busy);
        check("done", bif.exp_done, e_done);
        check("hit", bif.exp_hit, e_hit);
        check("box_on", box_on, e_on);
        check("rom_row", rom_row, e_row);
        check("rom_col", rom_col, e_col);
        check("rom_frame", rom_frame, e_frame);
        check("blocked", blocked, e_blk);
        check("boxes_left", boxes_left, e_left);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rand_cycles(input int n);
        int j, k;
        for (int c = 0; c < n; c++) begin
            frame_tick  = ($urandom_range(0, 3) == 0);
            bif.exp_req = ($urandom_range(0, 7) == 0);
            j = $urandom_range(0, N - 1);
            if ($urandom_range(0, 3) != 0) begin bif.exp_x = 10'(px[j]); bif.exp_y = 10'(py[j]); end
            else begin bif.exp_x = 10'($urandom); bif.exp_y = 10'($urandom); end
            k = $urandom_range(0, N - 1);
            v_x = 10'(px[k] + $urandom_range(0, 19) - 2);
            v_y = 10'(py[k] + $urandom_range(0, 19) - 2);
            k = $urandom_range(0, N - 1);
            b_x = 10'(px[k] + $urandom_range(0, 36) - 18);
            b_y = 10'(py[k] + $urandom_range(0, 36) - 18);
            step();
        end
        frame_tick = 0; bif.exp_req = 0;
    endtask

    initial begin
        int k, nbusy, ndone;
        logic hit_seen;
        bif.exp_req = 0; bif.exp_x = '0; bif.exp_y = '0;
        model_reset();
        step(); step();
        reset = 1'b1;
        step();

        // hit on slot 2: latency and busy width
        bif.exp_req = 1; bif.exp_x = 10'd160; bif.exp_y = 10'd48;
        step();
        bif.exp_req = 0;
        nbusy = 0; k = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bif.exp_busy) nbusy++;
            if (bif.exp_done) begin k = c; break; end
        end
        check("latency", k + 1, N + 2);
        check("busy_cycles", nbusy, N);
        check("hit_slot2", bif.exp_hit, 1);

        v_x = 10'd165; v_y = 10'd50; step();
        check("frame_slot2", rom_frame, 1);
        check("row_slot2", rom_row, 2);
        check("col_slot2", rom_col, 5);

        b_x = 10'd144; b_y = 10'd48; step();
        check("blocked_right", blocked, 4'b0001);

        v_x = 10'd42; v_y = 10'd42; step();
        check("prio_row", rom_row, 10);
        check("prio_col", rom_col, 10);

        v_x = 10'd215; v_y = 10'd100; step();
        check("edge_in", box_on, 1);
        v_x = 10'd216; #1;
        check("edge_late", box_on, 1);
        step();
        check("edge_out", box_on, 0);

        // miss, plus a request during the scan that must be dropped
        bif.exp_req = 1; bif.exp_x = 10'd0; bif.exp_y = 10'd0; step();
        bif.exp_req = 0; step(); step(); step();
        bif.exp_req = 1; bif.exp_x = 10'd200; bif.exp_y = 10'd100; step();
        bif.exp_req = 0;
        ndone = 0; hit_seen = 1'bx;
        for (int c = 0; c < 15; c++) begin
            step();
            if (bif.exp_done) begin ndone++; hit_seen = bif.exp_hit; end
        end
        check("miss_done_count", ndone, 1);
        check("miss_hit", hit_seen, 0);

        // break animation of slot 2
        v_x = 10'd165; v_y = 10'd50;
        for (int t = 0; t < AF - 1; t++) begin
            frame_tick = 1; step(); frame_tick = 0; step();
        end
        step();
        check("gone_box_on", box_on, 0);
        check("gone_left", boxes_left, N - 1);
        check("gone_blocked", blocked, 0);

        rand_cycles(1500);

        // reset in the middle of a scan
        bif.exp_req = 1; bif.exp_x = 10'd200; bif.exp_y = 10'd100; step();
        bif.exp_req = 0; step(); step(); step(); step();
        #2 reset = 1'b0; #1;
        check("rst_busy", bif.exp_busy, 0);
        check("rst_left", boxes_left, N);
        model_reset();
        check_all();
        step();
        reset = 1'b1;
        bif.exp_req = 1; bif.exp_x = 10'd160; bif.exp_y = 10'd48; step();
        bif.exp_req = 0;
        hit_seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (bif.exp_done) hit_seen = bif.exp_hit;
        end
        check("rehit_slot2", hit_seen, 1);

        rand_cycles(1500);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
